// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared types and constants for the pipeline sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pipe_state_t;

   localparam int DRAIN_CYCLES_DEF = 2;
   localparam int CNT_W_DEF        = 16;
   localparam int REG_ADR_W        = 3;

   // Bits needed to hold DRAIN_CYCLES-1 (never narrower than one bit).
   function automatic int drain_cnt_w(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// pipe_ctrl_if : hazard inputs and stage enables/flushes of the sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic [REG_ADR_W-1:0] rs_adr_id;
   logic [REG_ADR_W-1:0] rt_adr_id;
   logic                 uses_rs_id;
   logic                 uses_rt_id;
   logic [REG_ADR_W-1:0] regwrite_adr_ex;
   logic                 regwrite_ex;
   logic                 mem_read_ex;
   logic                 branch_taken_ex;
   logic                 is_halt_ex;
   logic                 mem_busy;
   logic                 restart;

   logic                 en_pc;
   logic                 en_ifid;
   logic                 en_idex;
   logic                 en_exmem;
   logic                 en_memwb;
   logic                 flush_ifid;
   logic                 flush_idex;
   logic                 halted;
   logic [CNT_W-1:0]     stall_cnt;

   modport master (
      output rs_adr_id, rt_adr_id, uses_rs_id, uses_rt_id, regwrite_adr_ex,
             regwrite_ex, mem_read_ex, branch_taken_ex, is_halt_ex, mem_busy, restart,
      input  en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
             halted, stall_cnt
   );

   modport slave (
      input  rs_adr_id, rt_adr_id, uses_rs_id, uses_rt_id, regwrite_adr_ex,
             regwrite_ex, mem_read_ex, branch_taken_ex, is_halt_ex, mem_busy, restart,
      output en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
             halted, stall_cnt
   );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
// ============================================================================
// hazard_detect : load-use compare between the ID operands and the EX load
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_ADR_W-1:0] rs_adr_id,
   input  logic [REG_ADR_W-1:0] rt_adr_id,
   input  logic                 uses_rs_id,
   input  logic                 uses_rt_id,
   input  logic [REG_ADR_W-1:0] regwrite_adr_ex,
   input  logic                 regwrite_ex,
   input  logic                 mem_read_ex,
   output logic                 load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = uses_rs_id && (rs_adr_id == regwrite_adr_ex);
   assign rt_hit = uses_rt_id && (rt_adr_id == regwrite_adr_ex);

   // r0 is hard-wired, so a load targeting it never creates a dependency.
   assign load_use = mem_read_ex && regwrite_ex && (regwrite_adr_ex != '0) && (rs_hit || rt_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : 5-stage pipeline sequencer (bubbles, flushes, freeze, halt/drain)
// Revision 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int CNT_W        = CNT_W_DEF
)(
   input  logic        clk,
   input  logic        reset,
   pipe_ctrl_if.slave  bus
);

   localparam int           DW         = drain_cnt_w(DRAIN_CYCLES);
   localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

   pipe_state_t      state_q,     state_d;
   logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             halted_q,    halted_d;

   logic load_use;
   logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
   logic flush_ifid, flush_idex;

   hazard_detect u_hazard_detect (
      .rs_adr_id       (bus.rs_adr_id),
      .rt_adr_id       (bus.rt_adr_id),
      .uses_rs_id      (bus.uses_rs_id),
      .uses_rt_id      (bus.uses_rt_id),
      .regwrite_adr_ex (bus.regwrite_adr_ex),
      .regwrite_ex     (bus.regwrite_ex),
      .mem_read_ex     (bus.mem_read_ex),
      .load_use        (load_use)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
         stall_cnt_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         halted_q    <= halted_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      stall_cnt_d = stall_cnt_q;
      en_pc       = 1'b1;
      en_ifid     = 1'b1;
      en_idex     = 1'b1;
      en_exmem    = 1'b1;
      en_memwb    = 1'b1;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;

      // While reset is held the pipe sees the plain RUN defaults.
      if (!reset) begin
         unique case (state_q)
            RUN: begin
               if (bus.mem_busy) begin
                  {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = '0;
               end else if (bus.is_halt_ex) begin
                  en_pc       = 1'b0;
                  en_ifid     = 1'b0;
                  flush_ifid  = 1'b1;
                  flush_idex  = 1'b1;
                  drain_cnt_d = DRAIN_INIT;
                  state_d     = DRAIN;
               end else if (bus.branch_taken_ex) begin
                  flush_ifid  = 1'b1;
                  flush_idex  = 1'b1;
               end else if (load_use) begin
                  en_pc       = 1'b0;
                  en_ifid     = 1'b0;
                  flush_idex  = 1'b1;
               end
               if (!en_pc && (stall_cnt_q != '1)) begin
                  stall_cnt_d = stall_cnt_q + 1'b1;
               end
            end
            DRAIN: begin
               if (bus.mem_busy) begin
                  {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = '0;
               end else begin
                  en_pc      = 1'b0;
                  en_ifid    = 1'b0;
                  flush_idex = 1'b1;
                  if (drain_cnt_q == '0) begin
                     state_d = HALTED;
                  end else begin
                     drain_cnt_d = drain_cnt_q - 1'b1;
                  end
               end
            end
            HALTED: begin
               {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = '0;
               if (bus.restart) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end

      halted_d = (state_d == HALTED);
   end

   assign bus.en_pc      = en_pc;
   assign bus.en_ifid    = en_ifid;
   assign bus.en_idex    = en_idex;
   assign bus.en_exmem   = en_exmem;
   assign bus.en_memwb   = en_memwb;
   assign bus.flush_ifid = flush_ifid;
   assign bus.flush_idex = flush_idex;
   assign bus.halted     = halted_q;
   assign bus.stall_cnt  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

   // {en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex}
   localparam logic [6:0] ALL_EN   = 7'b11111_00;
   localparam logic [6:0] BUBBLE   = 7'b00111_01;
   localparam logic [6:0] BRANCH   = 7'b11111_11;
   localparam logic [6:0] HALT_RUN = 7'b00111_11;
   localparam logic [6:0] DRAIN_V  = 7'b00111_01;
   localparam logic [6:0] FROZEN   = 7'b00000_00;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst4 = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   pipe_ctrl_if #(.CNT_W(16)) bus  ();
   pipe_ctrl_if #(.CNT_W(4))  bus4 ();

   pipe_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut  (.clk(clk), .reset(rst),  .bus(bus));
   pipe_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4))  dut4 (.clk(clk), .reset(rst4), .bus(bus4));

   always #5 clk = ~clk;

   function automatic logic [6:0] ctl();
      return {bus.en_pc, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb,
              bus.flush_ifid, bus.flush_idex};
   endfunction

   function automatic logic [6:0] ctl4();
      return {bus4.en_pc, bus4.en_ifid, bus4.en_idex, bus4.en_exmem, bus4.en_memwb,
              bus4.flush_ifid, bus4.flush_idex};
   endfunction

   task automatic clear_inputs();
      bus.rs_adr_id = '0;  bus.rt_adr_id = '0;  bus.uses_rs_id = 0; bus.uses_rt_id = 0;
      bus.regwrite_adr_ex = '0; bus.regwrite_ex = 0; bus.mem_read_ex = 0;
      bus.branch_taken_ex = 0;  bus.is_halt_ex = 0;  bus.mem_busy = 0; bus.restart = 0;
      bus4.rs_adr_id = '0; bus4.rt_adr_id = '0; bus4.uses_rs_id = 0; bus4.uses_rt_id = 0;
      bus4.regwrite_adr_ex = '0; bus4.regwrite_ex = 0; bus4.mem_read_ex = 0;
      bus4.branch_taken_ex = 0;  bus4.is_halt_ex = 0;  bus4.mem_busy = 0; bus4.restart = 0;
   endtask

   // Load into rd in EX; ID instruction operands rs/rt with their use flags.
   task automatic set_load(input logic [2:0] rd, input logic [2:0] rs, input logic urs,
                           input logic [2:0] rt, input logic urt);
      bus.mem_read_ex = 1; bus.regwrite_ex = 1; bus.regwrite_adr_ex = rd;
      bus.rs_adr_id = rs;  bus.uses_rs_id = urs;
      bus.rt_adr_id = rt;  bus.uses_rt_id = urt;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      bus.mem_busy = 1;
      @(negedge clk);
      n_cmp++; if (ctl() !== ALL_EN) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl(), ALL_EN); end
      n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
      n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt); end
      bus.mem_busy = 0;
      rst = 1'b0;
      #1;
      n_cmp++; if (ctl() !== ALL_EN) begin n_err++; $display("FAIL run_idle: got %b want %b", ctl(), ALL_EN); end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      set_load(3'd3, 3'd3, 1'b1, 3'd1, 1'b0);
      #1;
      n_cmp++; if (ctl() !== BUBBLE) begin n_err++; $display("FAIL lu_rs: got %b want %b", ctl(), BUBBLE); end
      @(negedge clk);
      clear_inputs();
      #1;
      n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_rs_cnt: got %0d want 1", bus.stall_cnt); end
      n_cmp++; if (ctl() !== ALL_EN) begin n_err++; $display("FAIL lu_clear: got %b want %b", ctl(), ALL_EN); end
      set_load(3'd5, 3'd2, 1'b1, 3'd5, 1'b1);
      #1;
      n_cmp++; if (ctl() !== BUBBLE) begin n_err++; $display("FAIL lu_rt: got %b want %b", ctl(), BUBBLE); end
      @(negedge clk);
      set_load(3'd6, 3'd6, 1'b0, 3'd6, 1'b0);
      #1;
      n_cmp++; if (ctl() !== ALL_EN) begin n_err++; $display("FAIL lu_unused: got %b want %b", ctl(), ALL_EN); end
      @(negedge clk);
      clear_inputs();
      n_cmp++; if (bus.stall_cnt !== 16'd2) begin n_err++; $display("FAIL lu_cnt2: got %0d want 2", bus.stall_cnt); end
   endtask

   task automatic test_r0_branch();
      set_load(3'd0, 3'd0, 1'b1, 3'd0, 1'b1);
      #1;
      n_cmp++; if (ctl() !== ALL_EN) begin n_err++; $display("FAIL r0_nostall: got %b want %b", ctl(), ALL_EN); end
      @(negedge clk);
      clear_inputs();
      n_cmp++; if (bus.stall_cnt !== 16'd2) begin n_err++; $display("FAIL r0_cnt: got %0d want 2", bus.stall_cnt); end
      bus.branch_taken_ex = 1;
      #1;
      n_cmp++; if (ctl() !== BRANCH) begin n_err++; $display("FAIL branch: got %b want %b", ctl(), BRANCH); end
      @(negedge clk);
      set_load(3'd4, 3'd4, 1'b1, 3'd0, 1'b0);
      #1;
      n_cmp++; if (ctl() !== BRANCH) begin n_err++; $display("FAIL branch_over_lu: got %b want %b", ctl(), BRANCH); end
      @(negedge clk);
      clear_inputs();
      n_cmp++; if (bus.stall_cnt !== 16'd2) begin n_err++; $display("FAIL branch_cnt: got %0d want 2", bus.stall_cnt); end
   endtask

   task automatic test_mem_busy();
      do_reset();
      set_load(3'd2, 3'd2, 1'b1, 3'd0, 1'b0);
      bus.mem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (ctl() !== FROZEN) begin n_err++; $display("FAIL busy_freeze[%0d]: got %b want %b", i, ctl(), FROZEN); end
         @(negedge clk);
      end
      bus.mem_busy = 0;
      #1;
      n_cmp++; if (bus.stall_cnt !== 16'd3) begin n_err++; $display("FAIL busy_cnt: got %0d want 3", bus.stall_cnt); end
      n_cmp++; if (ctl() !== BUBBLE) begin n_err++; $display("FAIL busy_then_bubble: got %b want %b", ctl(), BUBBLE); end
      @(negedge clk);
      clear_inputs();
      #1;
      n_cmp++; if (bus.stall_cnt !== 16'd4) begin n_err++; $display("FAIL busy_cnt4: got %0d want 4", bus.stall_cnt); end
      n_cmp++; if (ctl() !== ALL_EN) begin n_err++; $display("FAIL busy_resume: got %b want %b", ctl(), ALL_EN); end
   endtask

   task automatic test_halt();
      @(negedge clk);
      bus.is_halt_ex = 1;
      #1;
      n_cmp++; if (ctl() !== HALT_RUN) begin n_err++; $display("FAIL halt_run: got %b want %b", ctl(), HALT_RUN); end
      @(negedge clk);
      clear_inputs();
      bus.branch_taken_ex = 1;
      #1;
      n_cmp++; if (ctl() !== DRAIN_V) begin n_err++; $display("FAIL drain1: got %b want %b", ctl(), DRAIN_V); end
      n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL drain1_halted: got %b want 0", bus.halted); end
      @(negedge clk);
      n_cmp++; if (ctl() !== DRAIN_V) begin n_err++; $display("FAIL drain2: got %b want %b", ctl(), DRAIN_V); end
      n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL drain2_halted: got %b want 0", bus.halted); end
      @(negedge clk);
      clear_inputs();
      #1;
      n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL halted: got %b want 1", bus.halted); end
      n_cmp++; if (ctl() !== FROZEN) begin n_err++; $display("FAIL halted_ctl: got %b want %b", ctl(), FROZEN); end
      @(negedge clk);
      n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL halted_hold: got %b want 1", bus.halted); end
      bus.restart = 1;
      @(negedge clk);
      bus.restart = 0;
      #1;
      n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL restart_halted: got %b want 0", bus.halted); end
      n_cmp++; if (ctl() !== ALL_EN) begin n_err++; $display("FAIL restart_ctl: got %b want %b", ctl(), ALL_EN); end
   endtask

   task automatic test_drain_busy();
      @(negedge clk);
      bus.is_halt_ex = 1;
      @(negedge clk);
      bus.is_halt_ex = 0;
      // Entry edge has passed; 2 busy edges then 2 drain edges before HALTED.
      for (int k = 1; k <= 4; k++) begin
         bus.mem_busy = (k <= 2);
         #1;
         n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL drain_busy_early[%0d]: got %b want 0", k, bus.halted); end
         if (k == 1) begin
            n_cmp++; if (ctl() !== FROZEN) begin n_err++; $display("FAIL drain_busy_ctl: got %b want %b", ctl(), FROZEN); end
         end
         @(negedge clk);
      end
      bus.mem_busy = 0;
      n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL drain_busy_halted: got %b want 1", bus.halted); end
      bus.restart = 1;
      @(negedge clk);
      bus.restart = 0;
   endtask

   task automatic test_saturate_and_reset();
      rst4 = 1'b0;
      bus4.mem_busy = 1;
      for (int i = 0; i < 15; i++) @(negedge clk);
      n_cmp++; if (bus4.stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_reach: got %0d want 15", bus4.stall_cnt); end
      for (int i = 0; i < 5; i++) @(negedge clk);
      n_cmp++; if (bus4.stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d want 15", bus4.stall_cnt); end
      bus4.mem_busy = 0;
      bus4.is_halt_ex = 1;
      @(negedge clk);
      bus4.is_halt_ex = 0;
      #1;
      n_cmp++; if (ctl4() !== DRAIN_V) begin n_err++; $display("FAIL sat_drain: got %b want %b", ctl4(), DRAIN_V); end
      #2 rst4 = 1'b1;
      #1;
      n_cmp++; if (bus4.stall_cnt !== 4'd0) begin n_err++; $display("FAIL async_cnt: got %0d want 0", bus4.stall_cnt); end
      n_cmp++; if (bus4.halted !== 1'b0) begin n_err++; $display("FAIL async_halted: got %b want 0", bus4.halted); end
      @(negedge clk);
      rst4 = 1'b0;
      @(negedge clk);
      n_cmp++; if (ctl4() !== ALL_EN) begin n_err++; $display("FAIL async_run: got %b want %b", ctl4(), ALL_EN); end
      n_cmp++; if (bus4.halted !== 1'b0) begin n_err++; $display("FAIL async_run_halted: got %b want 0", bus4.halted); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_r0_branch();
      test_mem_busy();
      test_halt();
      test_drain_busy();
      test_saturate_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
